meter_pwm_bank: RTL
===================

# meter_pwm_bank

Multi-channel PWM driver for the moving-coil ammeter dials: one channel per needle (hours, minutes, seconds by default). Each channel holds a target duty written over a simple write port, slews its active duty toward the target by a bounded step once per PWM period so needles move smoothly, and clamps every target to a full-scale trim value. It sits between the time/LUT logic, which supplies calibrated duty codes, and the analog meter filter pins.

## Interface
- `CHANNELS`, 3: number of independent PWM outputs (1..16).
- `CNT_W`, 15: PWM counter width; period = 2^CNT_W clocks.
- `MAX_DUTY`, 2^CNT_W-1: full-scale trim; written duties above this are clamped to it.
- `STEP`, 64: maximum change of the active duty per PWM period (1..MAX_DUTY).
- `CH_W`, $clog2(CHANNELS) (min 1): channel index width.
---
- `clk` in 1: system clock.
- `Rst` in 1: synchronous reset, active-high.
- `En` in 1: run enable; low forces all outputs off and freezes the counter.
- `wr_en` in 1: write strobe, one write per cycle.
- `wr_ch` in CH_W: channel index for the write.
- `wr_duty` in CNT_W: requested duty in counter ticks.
- `wr_err` out 1: one-cycle pulse when a write targets `wr_ch >= CHANNELS`.
- `pwm_o` out CHANNELS: PWM outputs, bit i = channel i.
- `settled` out CHANNELS: bit i high when channel i's active duty equals its target.
- `period_strobe` out 1: one-cycle pulse on the first cycle of each PWM period.

## Operation
- Free-running counter `cnt` counts 0..2^CNT_W-1 and wraps to 0 while `En`=1. While `En`=0 it is held at 0.
- Each channel has a target register `tgt[i]` and an active register `cur[i]`, both CNT_W bits.
- Write: `wr_en`=1 with `wr_ch` < CHANNELS loads `tgt[wr_ch]` with min(`wr_duty`, MAX_DUTY). An out-of-range channel leaves all state unchanged and pulses `wr_err`. Writes are accepted regardless of `En`.
- Slew update happens only on the last cycle of a period (`cnt`=2^CNT_W-1 and `En`=1), for every channel at once:
  - if tgt > cur, then cur <= min(cur+STEP, tgt);
  - if tgt < cur, then cur <= max(cur-STEP, tgt);
  - otherwise cur is unchanged.
- Arithmetic is done at CNT_W+1 bits, so cur+STEP and cur-STEP never wrap.
- Because `cur` changes only at the period boundary, pulses are glitch-free: no partial or doubled pulse occurs in any period.
- PWM compare: `pwm_o[i]` is registered from (`cnt` < `cur[i]`) AND `En`.
  - cur=0 gives a constant low output.
  - cur=MAX_DUTY=2^CNT_W-1 gives high for all but one clock per period.
- `settled[i]` = (`cur[i]` == `tgt[i]`), taken from registers with no added delay.
- `period_strobe` is registered from (`cnt`==0 AND `En`).
- A write and a slew update in the same cycle: the slew uses the old `tgt`, and the new `tgt` is captured. Movement toward the new target starts at the next boundary.
- Multiple writes to the same channel within one period: the last write wins.

## Timing
- Reset (`Rst`=1 at an edge): `cnt`=0, all `tgt`=0, all `cur`=0, `pwm_o`=0, `settled`=all ones, `wr_err`=0, `period_strobe`=0. Reset mid-period aborts the period immediately; the next pulse starts from `cnt`=0 after release.
- A write in cycle t is visible in `tgt` and `settled` at t+1.
- `wr_err` is high in cycle t+1 only.
- `pwm_o` lags `cnt` by 1 clock. The first cycle of a period with the new `cur` drives `pwm_o` one clock after `cnt`=0.
- Slew latency: a distance of D ticks settles after ceil(D/STEP) period boundaries.
- `En` falling: `pwm_o` is 0 on the next clock, and `cnt` resets to 0 and holds there. `cur` and `tgt` are retained.
- `En` rising: counting starts from 0, and `period_strobe` pulses one clock later.
- Throughput: one write per clock; no backpressure.

## Test plan
Bench parameters: CNT_W=4 (period 16), CHANNELS=3, STEP=3, MAX_DUTY=12.
- Reset, then `En`=1 with no writes: `pwm_o`=000 throughout, `settled`=111, `period_strobe` every 16 clocks.
- Write ch1=9 at the start of period 0: `settled[1]`=0 at t+1. Active duty per period is 0, 3, 6, 9, 9. `pwm_o[1]` is high 3/6/9 clocks per period. `settled[1]` returns to 1 after the 3rd boundary.
- Write ch0=15: `tgt[0]`=12 (clamped). Write ch0=2 once cur=12: duty goes 12, 9, 6, 3, 2.
- Write on `wr_ch`=3: `wr_err` high for exactly 1 clock, all `tgt` unchanged. A simultaneous valid write on the next cycle is still accepted.
- Write ch2=6 exactly on the `cnt`=15 cycle: that boundary leaves `cur[2]`=0. `cur[2]` becomes 3 at the next boundary. No pulse is truncated; check a high-time of 0 or 3 each period.
- Drop `En` mid-pulse: `pwm_o`=0 next clock, `cnt` held at 0. Re-enable: pulse resumes from `cnt`=0 with the retained `cur`. Assert `Rst` mid-slew: all state reaches its reset values on the next clock.

Source files
------------

// File: rtl/meter_pwm_bank.sv
// meter_pwm_bank: one PWM channel per ammeter needle. Each channel holds a
// clamped target duty and slews its active duty toward it once per period.
module meter_pwm_bank #(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 15,
    parameter int MAX_DUTY = 2**CNT_W - 1,
    parameter int STEP     = 64,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                En,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_duty,
    output logic                wr_err,
    output logic [CHANNELS-1:0] pwm_o,
    output logic [CHANNELS-1:0] settled,
    output logic                period_strobe
);
    localparam logic [CNT_W-1:0] MAX_D    = CNT_W'(MAX_DUTY);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP);
    localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(CHANNELS);
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tgt_q [CHANNELS];
    logic [CNT_W-1:0]    tgt_d [CHANNELS];
    logic [CNT_W-1:0]    cur_q [CHANNELS];
    logic [CNT_W-1:0]    cur_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                wr_err_q, wr_err_d;
    logic                strobe_q, strobe_d;
    logic                boundary;
    logic                wr_ok;
    logic [CNT_W-1:0]    wr_val;
    logic [CNT_W:0]      cur_x, tgt_x;

    always_comb begin
        cnt_d    = En ? cnt_q + 1'b1 : '0;
        boundary = En && (cnt_q == CNT_LAST);
        wr_ok    = wr_en && ({1'b0, wr_ch} < CH_LIM);
        wr_val   = (wr_duty > MAX_D) ? MAX_D : wr_duty;
        wr_err_d = wr_en && !wr_ok;
        strobe_d = En && (cnt_q == '0);
        cur_x    = '0;
        tgt_x    = '0;
        pwm_d    = '0;
        settled  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            tgt_d[i] = tgt_q[i];
            cur_d[i] = cur_q[i];
            cur_x    = {1'b0, cur_q[i]};
            tgt_x    = {1'b0, tgt_q[i]};
            // Slew sees the pre-write target; a same-cycle write only lands in tgt.
            if (boundary) begin
                if (tgt_x > cur_x) begin
                    cur_d[i] = ((tgt_x - cur_x) <= STEP_X) ? tgt_q[i] : CNT_W'(cur_x + STEP_X);
                end else if (tgt_x < cur_x) begin
                    cur_d[i] = ((cur_x - tgt_x) <= STEP_X) ? tgt_q[i] : CNT_W'(cur_x - STEP_X);
                end
            end
            if (wr_ok && (wr_ch == CH_W'(i))) begin
                tgt_d[i] = wr_val;
            end
            pwm_d[i]   = En && (cnt_q < cur_q[i]);
            settled[i] = (cur_q[i] == tgt_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt_q    <= '0;
            pwm_q    <= '0;
            wr_err_q <= 1'b0;
            strobe_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            wr_err_q <= wr_err_d;
            strobe_q <= strobe_d;
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign pwm_o         = pwm_q;
    assign wr_err        = wr_err_q;
    assign period_strobe = strobe_q;
endmodule
